// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - control, config and status bundle of the program sequencer.
interface program_sequencer_if #(
  parameter int PC_BITS   = 9,
  parameter int TGT_BITS  = 8,
  parameter int NUM_PROGS = 4,
  parameter int CYC_BITS  = 16
);
  localparam int SEL_BITS = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic                req;
  logic [SEL_BITS-1:0] prog_sel;
  logic                cfg_we;
  logic [SEL_BITS-1:0] cfg_idx;
  logic [PC_BITS-1:0]  cfg_start;
  logic [PC_BITS-1:0]  cfg_done;
  logic                next_ins;
  logic                jump_flag;
  logic                jump_rel;
  logic [TGT_BITS-1:0] target;
  logic                abort;
  logic [PC_BITS-1:0]  pc;
  logic                running;
  logic                ack;
  logic                aborted;
  logic [CYC_BITS-1:0] cycle_count;

  modport master (
    output req, prog_sel, cfg_we, cfg_idx, cfg_start, cfg_done,
           next_ins, jump_flag, jump_rel, target, abort,
    input  pc, running, ack, aborted, cycle_count
  );

  modport slave (
    input  req, prog_sel, cfg_we, cfg_idx, cfg_start, cfg_done,
           next_ins, jump_flag, jump_rel, target, abort,
    output pc, running, ack, aborted, cycle_count
  );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - multi-program pc sequencer with start/done table and req/ack runs.
module program_sequencer #(
  parameter int PC_BITS   = 9,
  parameter int TGT_BITS  = 8,
  parameter int NUM_PROGS = 4,
  parameter int CYC_BITS  = 16
) (
  input logic             clock,
  input logic             reset_n,
  program_sequencer_if.slave bus
);
  localparam int SEL_BITS = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [PC_BITS-1:0]  act_done_q, act_done_d;
  logic [CYC_BITS-1:0] cyc_q, cyc_d;
  logic                ack_q, ack_d;
  logic                aborted_q, aborted_d;
  logic                running_q, running_d;
  logic [PC_BITS-1:0]  start_q [NUM_PROGS];
  logic [PC_BITS-1:0]  start_d [NUM_PROGS];
  logic [PC_BITS-1:0]  done_q  [NUM_PROGS];
  logic [PC_BITS-1:0]  done_d  [NUM_PROGS];

  logic [SEL_BITS-1:0] sel;
  logic [PC_BITS-1:0]  jump_pc;

  always_comb begin
    sel = (32'(bus.prog_sel) < NUM_PROGS) ? bus.prog_sel : '0;
    jump_pc = bus.jump_rel
      ? pc_q + {{(PC_BITS-TGT_BITS){bus.target[TGT_BITS-1]}}, bus.target}
      : {{(PC_BITS-TGT_BITS){1'b0}}, bus.target};

    state_d    = state_q;
    pc_d       = pc_q;
    act_done_d = act_done_q;
    cyc_d      = cyc_q;
    ack_d      = ack_q;
    aborted_d  = aborted_q;
    start_d    = start_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d    = ST_RUN;
          pc_d       = start_q[sel];
          act_done_d = done_q[sel];
          cyc_d      = '0;
          aborted_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CYC_BITS'(1);
        if (bus.abort) begin
          state_d   = ST_DONE;
          ack_d     = 1'b1;
          aborted_d = 1'b1;
        end else if (pc_q == act_done_q) begin
          // the done address is the last one executed; never step past it
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end else if (bus.next_ins) begin
          pc_d = bus.jump_flag ? jump_pc : pc_q + PC_BITS'(1);
        end
      end
      ST_DONE: begin
        if (!bus.req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // table reads above use the pre-write contents, so a same-edge write is not seen by the run
    if (bus.cfg_we && (32'(bus.cfg_idx) < NUM_PROGS)) begin
      start_d[bus.cfg_idx] = bus.cfg_start;
      done_d[bus.cfg_idx]  = bus.cfg_done;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      act_done_q <= '0;
      cyc_q      <= '0;
      ack_q      <= 1'b0;
      aborted_q  <= 1'b0;
      running_q  <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) begin
        start_q[i] <= '0;
        done_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      act_done_q <= act_done_d;
      cyc_q      <= cyc_d;
      ack_q      <= ack_d;
      aborted_q  <= aborted_d;
      running_q  <= running_d;
      start_q    <= start_d;
      done_q     <= done_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.running     = running_q;
  assign bus.ack         = ack_q;
  assign bus.aborted     = aborted_q;
  assign bus.cycle_count = cyc_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized and directed bench for program_sequencer against a behavioural model.
module tb_program_sequencer;
  localparam int PC_BITS   = 9;
  localparam int TGT_BITS  = 8;
  localparam int NUM_PROGS = 3;
  localparam int CYC_BITS  = 6;
  localparam int PC_MOD    = 1 << PC_BITS;
  localparam int CYC_MAX   = (1 << CYC_BITS) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  program_sequencer_if #(.PC_BITS(PC_BITS), .TGT_BITS(TGT_BITS),
                         .NUM_PROGS(NUM_PROGS), .CYC_BITS(CYC_BITS)) bus ();

  program_sequencer #(.PC_BITS(PC_BITS), .TGT_BITS(TGT_BITS),
                      .NUM_PROGS(NUM_PROGS), .CYC_BITS(CYC_BITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_start [NUM_PROGS];
  int m_done  [NUM_PROGS];
  int m_phase;   // 0 idle, 1 running, 2 waiting for req to fall
  int m_pc, m_act, m_cyc, m_ack, m_ab;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_PROGS; i++) begin
      m_start[i] = 0;
      m_done[i]  = 0;
    end
    m_phase = 0; m_pc = 0; m_act = 0; m_cyc = 0; m_ack = 0; m_ab = 0;
  endtask

  task automatic model_edge();
    int sel, off, t;
    if (m_phase == 0) begin
      if (bus.req) begin
        sel = (int'(bus.prog_sel) < NUM_PROGS) ? int'(bus.prog_sel) : 0;
        m_pc = m_start[sel]; m_act = m_done[sel];
        m_cyc = 0; m_ab = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_cyc = (m_cyc < CYC_MAX) ? m_cyc + 1 : CYC_MAX;
      if (bus.abort) begin
        m_phase = 2; m_ack = 1; m_ab = 1;
      end else if (m_pc == m_act) begin
        m_phase = 2; m_ack = 1;
      end else if (bus.next_ins) begin
        t = int'(bus.target);
        if (!bus.jump_flag) m_pc = (m_pc + 1) % PC_MOD;
        else if (!bus.jump_rel) m_pc = t;
        else begin
          off  = (t >= (1 << (TGT_BITS-1))) ? t - (1 << TGT_BITS) : t;
          m_pc = (m_pc + off + PC_MOD) % PC_MOD;
        end
      end
    end else begin
      if (!bus.req) begin
        m_phase = 0; m_ack = 0;
      end
    end
    if (bus.cfg_we && int'(bus.cfg_idx) < NUM_PROGS) begin
      m_start[bus.cfg_idx] = int'(bus.cfg_start);
      m_done[bus.cfg_idx]  = int'(bus.cfg_done);
    end
  endtask

  task automatic check_outputs();
    check_eq("pc", 32'(bus.pc), 32'(m_pc));
    check_eq("running", 32'(bus.running), 32'(m_phase == 1));
    check_eq("ack", 32'(bus.ack), 32'(m_ack));
    if (m_ack != 0) check_eq("aborted", 32'(bus.aborted), 32'(m_ab));
    check_eq("cycle_count", 32'(bus.cycle_count), 32'(m_cyc));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic cfg_write(input int idx, input int s, input int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = idx[1:0];
    bus.cfg_start = s[PC_BITS-1:0];
    bus.cfg_done  = d[PC_BITS-1:0];
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_run(input int sel);
    bus.prog_sel = sel[1:0];
    bus.req      = 1'b1;
    step();
  endtask

  task automatic run_until_ack(input int budget);
    int n = 0;
    while (!bus.ack && n < budget) begin
      step();
      n++;
    end
    if (!bus.ack) check_eq("ack_timeout", 32'(bus.ack), 32'd1);
  endtask

  task automatic finish_run();
    bus.req = 1'b0;
    step();
  endtask

  initial begin
    bus.req = 0; bus.prog_sel = 0; bus.cfg_we = 0; bus.cfg_idx = 0;
    bus.cfg_start = 0; bus.cfg_done = 0; bus.next_ins = 0; bus.jump_flag = 0;
    bus.jump_rel = 0; bus.target = 0; bus.abort = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_eq("reset_pc", 32'(bus.pc), 32'd0);
    check_eq("reset_running", 32'(bus.running), 32'd0);
    check_eq("reset_ack", 32'(bus.ack), 32'd0);
    check_eq("reset_aborted", 32'(bus.aborted), 32'd0);
    check_eq("reset_cyc", 32'(bus.cycle_count), 32'd0);
    reset_n = 1'b1;

    // straight-line run 10..14
    cfg_write(1, 10, 14);
    bus.next_ins = 1;
    start_run(1);
    check_eq("t1_first_pc", 32'(bus.pc), 32'd10);
    run_until_ack(20);
    check_eq("t1_pc_end", 32'(bus.pc), 32'd14);
    check_eq("t1_cyc", 32'(bus.cycle_count), 32'd5);
    check_eq("t1_aborted", 32'(bus.aborted), 32'd0);
    finish_run();
    check_eq("t1_ack_low", 32'(bus.ack), 32'd0);

    // wrap through the top of the address space
    cfg_write(0, 500, 3);
    start_run(0);
    run_until_ack(40);
    check_eq("t2_pc_end", 32'(bus.pc), 32'd3);
    check_eq("t2_cyc", 32'(bus.cycle_count), 32'd16);
    finish_run();

    // relative and absolute jumps
    cfg_write(2, 18, 200);
    start_run(2);
    step(); step();
    check_eq("t3_at20", 32'(bus.pc), 32'd20);
    bus.jump_flag = 1; bus.jump_rel = 1; bus.target = 8'hFC;
    step();
    check_eq("t3_rel", 32'(bus.pc), 32'd16);
    bus.jump_rel = 0; bus.target = 8'h40;
    step();
    check_eq("t3_abs", 32'(bus.pc), 32'd64);
    bus.jump_flag = 0; bus.abort = 1;
    step();
    bus.abort = 0;
    finish_run();

    // abort mid-run, ack held while req stays high
    cfg_write(1, 8, 100);
    start_run(1);
    repeat (4) step();
    bus.abort = 1;
    step();
    bus.abort = 0;
    check_eq("t4_ack", 32'(bus.ack), 32'd1);
    check_eq("t4_aborted", 32'(bus.aborted), 32'd1);
    check_eq("t4_pc", 32'(bus.pc), 32'd12);
    repeat (3) begin
      step();
      check_eq("t4_ack_hold", 32'(bus.ack), 32'd1);
    end
    finish_run();
    check_eq("t4_ack_drop", 32'(bus.ack), 32'd0);
    check_eq("t4_running", 32'(bus.running), 32'd0);

    // start==done, then held pc with next_ins low
    cfg_write(0, 7, 7);
    start_run(0);
    check_eq("t5_pc", 32'(bus.pc), 32'd7);
    check_eq("t5_ack0", 32'(bus.ack), 32'd0);
    step();
    check_eq("t5_ack1", 32'(bus.ack), 32'd1);
    finish_run();
    cfg_write(2, 30, 40);
    bus.next_ins = 0;
    start_run(2);
    repeat (3) step();
    check_eq("t5_hold", 32'(bus.pc), 32'd30);
    bus.abort = 1;
    step();
    bus.abort = 0;
    finish_run();

    // out-of-range prog_sel falls back to entry 0; out-of-range cfg_idx is dropped
    cfg_write(0, 40, 41);
    cfg_write(3, 77, 78);
    bus.next_ins = 1;
    start_run(3);
    check_eq("sel_oob_pc", 32'(bus.pc), 32'd40);
    run_until_ack(10);
    finish_run();

    // cycle counter saturation
    cfg_write(0, 5, 6);
    bus.next_ins = 0;
    start_run(0);
    repeat (70) step();
    check_eq("sat_cyc", 32'(bus.cycle_count), 32'(CYC_MAX));
    bus.next_ins = 1;
    run_until_ack(10);
    check_eq("sat_cyc_end", 32'(bus.cycle_count), 32'(CYC_MAX));
    finish_run();

    // table write during a run does not move the running done address
    cfg_write(1, 50, 55);
    start_run(1);
    step();
    cfg_write(1, 50, 99);
    run_until_ack(20);
    check_eq("t6_old_done", 32'(bus.pc), 32'd55);
    finish_run();

    // asynchronous reset mid-run clears everything including the table
    start_run(2);
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_pc", 32'(bus.pc), 32'd0);
    check_eq("rst_running", 32'(bus.running), 32'd0);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    model_reset();
    bus.req = 0;
    @(negedge clock);
    reset_n = 1'b1;
    start_run(1);
    check_eq("rst_table", 32'(bus.pc), 32'd0);
    step();
    check_eq("rst_table_ack", 32'(bus.ack), 32'd1);
    finish_run();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int s;
      bus.cfg_we = ($urandom_range(0, 7) == 0);
      bus.cfg_idx = 2'($urandom_range(0, 3));
      s = $urandom_range(0, PC_MOD - 1);
      bus.cfg_start = s[PC_BITS-1:0];
      s = (s + $urandom_range(0, 12)) % PC_MOD;
      bus.cfg_done  = s[PC_BITS-1:0];
      bus.prog_sel  = 2'($urandom_range(0, 3));
      bus.req       = (m_phase == 2) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0);
      bus.next_ins  = ($urandom_range(0, 3) != 0);
      bus.jump_flag = ($urandom_range(0, 9) == 0);
      bus.jump_rel  = $urandom_range(0, 1) == 1;
      bus.target    = 8'($urandom_range(0, 255));
      bus.abort     = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
